imm_gen_arbiter: RTL
====================

Name: imm_gen_arbiter

Overview:
Shares one immediate-decode datapath between NUM_REQ core decode stages in the multicore RISC-V design. Each core presents an instruction with a valid/ready handshake. A round-robin arbiter grants one request per cycle. The granted instruction's immediate is decoded and registered into that core's 1-entry response slot, which the core drains with its own valid/ready handshake.

Parameters:
NUM_REQ, 2, number of requesting cores (2..8)
XLEN, 32, instruction and immediate width (fixed 32; parameter kept for package consistency)

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  synchronous, active-low reset; sampled on rising edge of clk
req_valid  input  NUM_REQ  core i presents an instruction
req_instr  input  NUM_REQ x XLEN  instruction word from core i
req_ready  output  NUM_REQ  core i's request accepted this cycle
rsp_valid  output  NUM_REQ  slot i holds a decoded immediate
rsp_imm  output  NUM_REQ x XLEN  decoded immediate for core i
rsp_err  output  NUM_REQ  slot i instruction had no immediate format
rsp_ready  input  NUM_REQ  core i consumes slot i this cycle

Behaviour:
- Reset (reset==0 at clk edge): rsp_valid=0, rsp_imm=0, rsp_err=0, RR pointer=0. Applies mid-transaction; occupied slots are discarded. req_ready is forced 0 while reset is low.
- Slot i "free" = !rsp_valid[i] || rsp_ready[i] (drain and refill allowed in the same cycle).
- Eligible i = req_valid[i] && free(i).
- Arbitration: search from RR pointer upward with wrap. The first eligible index wins. At most one grant per cycle.
- req_ready[i]=1 only for the winner. req_ready is combinational from req_valid, rsp_valid, rsp_ready and the pointer. A request with req_valid=0 never gets ready.
- Pointer update: on a grant to k, pointer <= (k+1) mod NUM_REQ. With no grant, the pointer holds.
- Latency: accepted at edge N, so rsp_valid[k]=1 with rsp_imm/rsp_err valid after edge N. Throughput is 1 grant/cycle aggregate and 1/cycle per core if it drains every cycle.
- Slot i on drain without refill: rsp_valid<=0. rsp_imm and rsp_err hold their last value (don't-care).
- Slots of non-granted cores are unchanged.
- Decode on opcode instr[6:0]. All sign extensions use instr[31].
  - I (0010011): funct3 001/101 give zero-extended instr[24:20]. Otherwise sext(instr[31:20]).
  - Load 0000011 and JALR 1100111: sext(instr[31:20]).
  - S (0100011): sext({instr[31:25],instr[11:7]}).
  - B (1100011): sext({instr[31],instr[7],instr[30:25],instr[11:8],1'b0}).
  - U, LUI 0110111 and AUIPC 0010111: {instr[31:12],12'b0}.
  - J (1101111): sext({instr[31],instr[19:12],instr[20],instr[30:21],1'b0}).
  - Any other opcode: imm=0, rsp_err=1. rsp_err=0 for all listed opcodes.
- No deadlock: a core with a held request is granted within NUM_REQ cycles, given its slot drains.

Decomposition:
- Package imm_pkg holds:
  - opcode localparams (OPC_OP_IMM, OPC_LOAD, OPC_JALR, OPC_STORE, OPC_BRANCH, OPC_LUI, OPC_AUIPC, OPC_JAL)
  - typedef enum imm_fmt_e {FMT_I, FMT_ISH, FMT_S, FMT_B, FMT_U, FMT_J, FMT_NONE}
  - XLEN
- One sub-module, imm_decode: purely combinational, instr in, imm and err out. It is instantiated once on the granted instruction mux output. The arbiter, pointer and slots stay in imm_gen_arbiter.

Test Plan:
- After reset, core0 sends 0xFFF00093 (ADDI x1,x0,-1). Required: req_ready[0]=1 that cycle; next cycle rsp_valid[0]=1, rsp_imm[0]=0xFFFFFFFF, rsp_err[0]=0.
- Both cores hold valid from reset release, with rsp_ready=1. Required: grants alternate 0,1,0,1; core1 sends 0xFE000EE3 (BEQ -4) and gets rsp_imm[1]=0xFFFFFFFC.
- Backpressure: rsp_valid[0]=1 with rsp_ready[0]=0 and core0 requesting. Required: req_ready[0]=0 held. Core1 sends 0x123450B7 (LUI) and is granted every cycle, with rsp_imm[1]=0x12345000. Raising rsp_ready[0] gives core0 the grant the same cycle.
- Format sweep on core0 (back-to-back, drain every cycle; one response per cycle):
  - 0x0080006F (JAL +8) gives 0x00000008
  - 0xFE112E23 (SW, offset -4) gives 0xFFFFFFFC
  - 0x40515093 (SRAI shamt 5) gives 0x00000005
  - 0x00000033 (R-type) gives imm 0, rsp_err=1
- Reset mid-operation: both slots full, then reset=0 for one edge. Required: rsp_valid=00 and req_ready=00 during reset. Afterward the pointer is 0, so with both cores requesting, core0 is granted first.

Source files
------------

// File: rtl/imm_pkg.sv
//------------------------------------------------------------------------------
// imm_pkg : shared opcodes, immediate-format enum and word width
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package imm_pkg;

  localparam int XLEN = 32;

  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  typedef enum logic [2:0] {
    FMT_I,
    FMT_ISH,
    FMT_S,
    FMT_B,
    FMT_U,
    FMT_J,
    FMT_NONE
  } imm_fmt_e;

endpackage

`default_nettype wire

// File: rtl/imm_decode.sv
//------------------------------------------------------------------------------
// imm_decode : combinational RISC-V immediate extractor with no-format flag
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module imm_decode
  import imm_pkg::*;
(
  input  logic [XLEN-1:0] instr,
  output logic [XLEN-1:0] imm,
  output logic            err
);

  imm_fmt_e fmt;
  logic     sign;

  assign sign = instr[31];

  always_comb begin
    fmt = FMT_NONE;
    case (instr[6:0])
      OPC_OP_IMM: begin
        // Shift-immediates carry an unsigned shamt instead of a signed imm
        if (instr[14:12] == 3'b001 || instr[14:12] == 3'b101) fmt = FMT_ISH;
        else                                                  fmt = FMT_I;
      end
      OPC_LOAD, OPC_JALR:  fmt = FMT_I;
      OPC_STORE:           fmt = FMT_S;
      OPC_BRANCH:          fmt = FMT_B;
      OPC_LUI, OPC_AUIPC:  fmt = FMT_U;
      OPC_JAL:             fmt = FMT_J;
      default:             fmt = FMT_NONE;
    endcase
  end

  always_comb begin
    imm = '0;
    err = 1'b0;
    case (fmt)
      FMT_I:   imm = {{20{sign}}, instr[31:20]};
      FMT_ISH: imm = {27'b0, instr[24:20]};
      FMT_S:   imm = {{20{sign}}, instr[31:25], instr[11:7]};
      FMT_B:   imm = {{19{sign}}, sign, instr[7], instr[30:25], instr[11:8], 1'b0};
      FMT_U:   imm = {instr[31:12], 12'b0};
      FMT_J:   imm = {{11{sign}}, sign, instr[19:12], instr[20], instr[30:21], 1'b0};
      default: begin
        imm = '0;
        err = 1'b1;
      end
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/imm_gen_arbiter.sv
//------------------------------------------------------------------------------
// imm_gen_arbiter : round-robin sharing of one immediate decoder across cores
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module imm_gen_arbiter
  import imm_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int XLEN    = imm_pkg::XLEN
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [NUM_REQ-1:0]              req_valid,
  input  logic [NUM_REQ-1:0][XLEN-1:0]    req_instr,
  output logic [NUM_REQ-1:0]              req_ready,
  output logic [NUM_REQ-1:0]              rsp_valid,
  output logic [NUM_REQ-1:0][XLEN-1:0]    rsp_imm,
  output logic [NUM_REQ-1:0]              rsp_err,
  input  logic [NUM_REQ-1:0]              rsp_ready
);

  localparam int             PTR_W   = $clog2(NUM_REQ);
  localparam logic [PTR_W:0] NUM_EXT = (PTR_W+1)'(NUM_REQ);
  localparam logic [PTR_W-1:0] LAST  = PTR_W'(NUM_REQ - 1);

  logic [PTR_W-1:0]   ptr;
  logic [NUM_REQ-1:0] eligible;
  logic               grant_any;
  logic [PTR_W-1:0]   grant_idx;
  logic [PTR_W:0]     cand;
  logic [XLEN-1:0]    gnt_instr;
  logic [XLEN-1:0]    dec_imm;
  logic               dec_err;

  // A slot may be refilled in the same cycle its consumer drains it
  assign eligible = req_valid & (~rsp_valid | rsp_ready);

  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    cand      = '0;
    for (int off = 0; off < NUM_REQ; off++) begin
      cand = {1'b0, ptr} + (PTR_W+1)'(off);
      if (cand >= NUM_EXT) cand = cand - NUM_EXT;
      if (!grant_any && eligible[cand[PTR_W-1:0]]) begin
        grant_any = 1'b1;
        grant_idx = cand[PTR_W-1:0];
      end
    end
  end

  always_comb begin
    req_ready = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_ready[i] = reset && grant_any && (grant_idx == PTR_W'(i));
    end
  end

  assign gnt_instr = req_instr[grant_idx];

  imm_decode u_imm_decode (
    .instr (gnt_instr),
    .imm   (dec_imm),
    .err   (dec_err)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      ptr       <= '0;
      rsp_valid <= '0;
      rsp_imm   <= '0;
      rsp_err   <= '0;
    end else begin
      if (grant_any) ptr <= (grant_idx == LAST) ? '0 : grant_idx + PTR_W'(1);
      for (int i = 0; i < NUM_REQ; i++) begin
        if (req_ready[i]) begin
          rsp_valid[i] <= 1'b1;
          rsp_imm[i]   <= dec_imm;
          rsp_err[i]   <= dec_err;
        end else if (rsp_ready[i]) begin
          rsp_valid[i] <= 1'b0;
        end
      end
    end
  end

endmodule

`default_nettype wire
